leve1_div_seq: RTL

Multi-cycle divide sequencer for the LEVE1 RV64 execute stage. It accepts DIV/DIVU/REM/REMU and their W variants from EX and runs a shared restoring-division datapath, one quotient bit per cycle. It resolves divide-by-zero and signed overflow on a fast path, applies RV64M result rules, and returns the result over a valid/ready handshake. EX stalls while IREADY is low or while a result is pending.

---
 rtl/leve1_div_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/leve1_div_seq.sv
// Multi-cycle divide sequencer for the LEVE1 RV64 execute stage.
// Restoring division, one quotient bit per cycle; divide-by-zero and signed
// overflow resolve in a single cycle. Results return over a valid/ready pair.
module leve1_div_seq #(
  parameter int unsigned XLEN = 64
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            IVALID,
  output logic            IREADY,
  input  logic [2:0]      IFUNCT3,
  input  logic            IWORD,
  input  logic [XLEN-1:0] IRS1,
  input  logic [XLEN-1:0] IRS2,
  input  logic            IFLUSH,
  output logic            OVALID,
  input  logic            OREADY,
  output logic [XLEN-1:0] ORESULT,
  output logic            BUSY
);

  localparam int unsigned HALF = XLEN / 2;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] dvd_q, dvd_d;   // dividend magnitude, consumed from the MSB
  logic [XLEN-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            rem_op_q, rem_op_d;
  logic            word_q, word_d;
  logic            sgn_q, sgn_d;
  logic            dneg_q, dneg_d;
  logic            qneg_q, qneg_d;

  // Request decode
  logic            is_signed, is_rem;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg;
  logic            a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] fast_res;

  // Iteration datapath
  logic [XLEN:0]   rem_sh, sub;
  logic            q_bit;
  logic [XLEN-1:0] rem_nx, quo_nx, q_raw, q_fix, r_fix, sel_res, final_res;

  // funct3[2] distinguishes MUL from DIV upstream and carries no meaning here
  logic unused_funct3;
  assign unused_funct3 = IFUNCT3[2];

  // Low half sign-extended to the full width, used for every W result
  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  // Operand extension, magnitudes and fast-path result
  always_comb begin
    is_signed = ~IFUNCT3[0];
    is_rem    = IFUNCT3[1];
    if (IWORD) begin
      a_ext   = is_signed ? sext_w(IRS1) : {{HALF{1'b0}}, IRS1[HALF-1:0]};
      b_ext   = is_signed ? sext_w(IRS2) : {{HALF{1'b0}}, IRS2[HALF-1:0]};
      min_neg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      a_ext   = IRS1;
      b_ext   = IRS2;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_abs    = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_abs    = b_neg ? (~b_ext + 1'b1) : b_ext;
    div_zero = (b_ext == '0);
    overflow = is_signed & (a_ext == min_neg) & (b_ext == '1);
    if (div_zero) begin
      fast_res = is_rem ? a_ext : '1;
    end else begin
      fast_res = is_rem ? '0 : a_ext;
    end
    if (IWORD) begin
      fast_res = sext_w(fast_res);
    end
  end

  // One restoring step plus sign fix-up of the would-be final result
  always_comb begin
    rem_sh = {rem_q, dvd_q[XLEN-1]};
    sub    = rem_sh - {1'b0, dvs_q};
    // no borrow means the shifted remainder covered the divisor
    q_bit  = ~sub[XLEN];
    rem_nx = q_bit ? sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], q_bit};
    q_raw  = word_q ? {{HALF{1'b0}}, quo_nx[HALF-1:0]} : quo_nx;
    q_fix  = (sgn_q & qneg_q) ? (~q_raw + 1'b1) : q_raw;
    r_fix  = (sgn_q & dneg_q) ? (~rem_nx + 1'b1) : rem_nx;
    sel_res   = rem_op_q ? r_fix : q_fix;
    final_res = word_q ? sext_w(sel_res) : sel_res;
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    rem_op_d = rem_op_q;
    word_d   = word_q;
    sgn_d    = sgn_q;
    dneg_d   = dneg_q;
    qneg_d   = qneg_q;
    case (state_q)
      StIdle: begin
        if (IVALID && !IFLUSH) begin
          if (div_zero || overflow) begin
            result_d = fast_res;
            state_d  = StDone;
          end else begin
            // W dividends are left-aligned so the MSB feed is width-agnostic
            dvd_d    = IWORD ? {a_abs[HALF-1:0], {HALF{1'b0}}} : a_abs;
            dvs_d    = b_abs;
            rem_d    = '0;
            quo_d    = '0;
            cnt_d    = IWORD ? 6'd31 : 6'd63;
            rem_op_d = is_rem;
            word_d   = IWORD;
            sgn_d    = is_signed;
            dneg_d   = a_neg;
            qneg_d   = a_neg ^ b_neg;
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        if (IFLUSH) begin
          state_d = StIdle;
        end else begin
          dvd_d = {dvd_q[XLEN-2:0], 1'b0};
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd0) begin
            cnt_d    = 6'd0;
            result_d = final_res;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        if (IFLUSH || OREADY) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= StIdle;
      result_q <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      rem_op_q <= 1'b0;
      word_q   <= 1'b0;
      sgn_q    <= 1'b0;
      dneg_q   <= 1'b0;
      qneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      rem_op_q <= rem_op_d;
      word_q   <= word_d;
      sgn_q    <= sgn_d;
      dneg_q   <= dneg_d;
      qneg_q   <= qneg_d;
    end
  end

  assign IREADY  = (state_q == StIdle);
  assign BUSY    = (state_q != StIdle);
  assign OVALID  = (state_q == StDone);
  assign ORESULT = result_q;

endmodule
